// File: rtl/seg_to_bcd_monitor_if.sv
// Seven-segment display bus seen by the monitor: the segment pattern in,
// decoded digit, sequence-check pulses and error count out.
interface seg_to_bcd_monitor_if;
  logic [7:0] disp;
  logic [3:0] digit;
  logic       valid;
  logic       new_digit;
  logic       step_ok;
  logic       step_err;
  logic       invalid;
  logic [7:0] err_count;

  modport master (
    output disp,
    input  digit, valid, new_digit, step_ok, step_err, invalid, err_count
  );

  modport slave (
    input  disp,
    output digit, valid, new_digit, step_ok, step_err, invalid, err_count
  );
endinterface

// File: rtl/seg_to_bcd_monitor.sv
// Display-path checker: debounces the segment bus, decodes accepted patterns
// to BCD and verifies that successive digits follow the mod-10 up-count.
module seg_to_bcd_monitor #(
  parameter int unsigned STABLE_CYCLES = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  seg_to_bcd_monitor_if.slave  bus
);

  typedef enum logic {EMPTY, TRACK} state_e;

  localparam logic [3:0] CNT_MAX = 4'(STABLE_CYCLES - 1);

  logic [6:0] samp;
  logic [6:0] acc_pat;
  logic [3:0] cnt;
  logic       accept;

  state_e     state, state_d;
  logic [3:0] prev, prev_d;
  logic [3:0] digit_q, digit_d;
  logic       valid_q, valid_d;
  logic       new_q, new_d;
  logic       ok_q, ok_d;
  logic       err_q, err_d;
  logic       inv_q, inv_d;
  logic [7:0] err_count_q;

  logic [3:0] dec_digit;
  logic       dec_legal;
  logic       dec_blank;
  logic [3:0] succ;

  // A pattern is taken once it has been stable for the full window and
  // differs from the last one taken, so a held pattern fires only once.
  assign accept = (cnt == CNT_MAX) && (samp != acc_pat);

  always_comb begin
    // NOTE: every combinational output gets a default first, otherwise a
    // missing branch infers a latch.
    dec_digit = 4'd0;
    dec_legal = 1'b1;
    unique case (samp)
      7'h3F: dec_digit = 4'd0;
      7'h06: dec_digit = 4'd1;
      7'h5B: dec_digit = 4'd2;
      7'h4F: dec_digit = 4'd3;
      7'h66: dec_digit = 4'd4;
      7'h6D: dec_digit = 4'd5;
      7'h7D: dec_digit = 4'd6;
      7'h07: dec_digit = 4'd7;
      7'h7F: dec_digit = 4'd8;
      7'h6F: dec_digit = 4'd9;
      default: dec_legal = 1'b0;
    endcase
  end

  assign dec_blank = (samp == 7'h00);
  assign succ      = (prev == 4'd9) ? 4'd0 : prev + 4'd1;

  always_comb begin
    state_d = state;
    prev_d  = prev;
    digit_d = digit_q;
    valid_d = valid_q;
    new_d   = 1'b0;
    ok_d    = 1'b0;
    err_d   = 1'b0;
    inv_d   = 1'b0;
    if (accept) begin
      if (dec_blank) begin
        valid_d = 1'b0;
        state_d = EMPTY;
      end else if (dec_legal) begin
        digit_d = dec_digit;
        valid_d = 1'b1;
        new_d   = 1'b1;
        prev_d  = dec_digit;
        state_d = TRACK;
        if (state == TRACK) begin
          if (dec_digit == succ) ok_d  = 1'b1;
          else                   err_d = 1'b1;
        end
      end else begin
        inv_d   = 1'b1;
        valid_d = 1'b0;
        state_d = EMPTY;
      end
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    if (rst) state <= EMPTY;
    else     state <= state_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      samp        <= 7'h00;
      cnt         <= 4'd0;
      acc_pat     <= 7'h00;
      prev        <= 4'd0;
      digit_q     <= 4'd0;
      valid_q     <= 1'b0;
      new_q       <= 1'b0;
      ok_q        <= 1'b0;
      err_q       <= 1'b0;
      inv_q       <= 1'b0;
      err_count_q <= 8'd0;
    end else begin
      samp <= bus.disp[6:0];
      if (bus.disp[6:0] != samp) cnt <= 4'd0;
      else if (cnt != CNT_MAX)   cnt <= cnt + 4'd1;
      if (accept) acc_pat <= samp;
      prev    <= prev_d;
      digit_q <= digit_d;
      valid_q <= valid_d;
      new_q   <= new_d;
      ok_q    <= ok_d;
      err_q   <= err_d;
      inv_q   <= inv_d;
      if ((err_d || inv_d) && err_count_q != 8'hFF)
        err_count_q <= err_count_q + 8'd1;
    end
  end

  assign bus.digit     = digit_q;
  assign bus.valid     = valid_q;
  assign bus.new_digit = new_q;
  assign bus.step_ok   = ok_q;
  assign bus.step_err  = err_q;
  assign bus.invalid   = inv_q;
  assign bus.err_count = err_count_q;

endmodule

// File: tb/tb_seg_to_bcd_monitor.sv
// Directed bench for seg_to_bcd_monitor: counting sequence, step errors,
// glitch rejection, latency, illegal/blank patterns, saturation and reset.
module tb_seg_to_bcd_monitor;

  logic clk = 1'b0;
  logic rst;

  seg_to_bcd_monitor_if bus ();

  seg_to_bcd_monitor #(.STABLE_CYCLES(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int c_new, c_ok, c_err, c_inv;
  int c_multi = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic clr();
    c_new = 0;
    c_ok  = 0;
    c_err = 0;
    c_inv = 0;
  endtask

  // Drives a pattern for n cycles, tallying pulses at each falling edge.
  task automatic run(input logic [7:0] pat, input int n);
    bus.disp = pat;
    repeat (n) begin
      @(negedge clk);
      c_new += int'(bus.new_digit);
      c_ok  += int'(bus.step_ok);
      c_err += int'(bus.step_err);
      c_inv += int'(bus.invalid);
      if (int'(bus.step_ok) + int'(bus.step_err) + int'(bus.invalid) > 1) c_multi++;
    end
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_digit"}, 32'(bus.digit), 0);
    check({tag, "_valid"}, 32'(bus.valid), 0);
    check({tag, "_errcnt"}, 32'(bus.err_count), 0);
    check({tag, "_pulses"},
          32'({bus.new_digit, bus.step_ok, bus.step_err, bus.invalid}), 0);
  endtask

  logic [7:0] pats [10] = '{8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66,
                            8'h6D, 8'h7D, 8'h07, 8'h7F, 8'h6F};

  initial begin
    rst      = 1'b1;
    bus.disp = 8'h00;
    repeat (2) @(negedge clk);
    check_reset_state("reset");
    rst = 1'b0;
    clr();
    run(8'h00, 5);
    check("blank_after_reset_new", 32'(c_new), 0);

    // Full 0..9,0 count
    clr();
    for (int i = 0; i < 10; i++) run(pats[i], 10);
    run(8'h3F, 10);
    check("count_new", 32'(c_new), 11);
    check("count_ok", 32'(c_ok), 10);
    check("count_err", 32'(c_err + c_inv), 0);
    check("count_errcnt", 32'(bus.err_count), 0);
    check("count_digit", 32'(bus.digit), 0);
    check("count_valid", 32'(bus.valid), 1);

    // Load 5 after 4, then an out-of-sequence 0
    run(8'h00, 10);
    clr();
    run(8'h66, 10);
    run(8'h6D, 10);
    check("load_new", 32'(c_new), 2);
    check("load_ok", 32'(c_ok), 1);
    check("load_err", 32'(c_err), 0);
    clr();
    run(8'h3F, 10);
    check("seq_err", 32'(c_err), 1);
    check("seq_err_ok", 32'(c_ok), 0);
    check("seq_errcnt", 32'(bus.err_count), 1);
    check("seq_digit", 32'(bus.digit), 0);
    check("seq_valid", 32'(bus.valid), 1);

    // One-cycle glitch is rejected
    run(8'h06, 10);
    clr();
    run(8'h5B, 1);
    run(8'h06, 10);
    check("glitch_new", 32'(c_new), 0);
    check("glitch_pulses", 32'(c_ok + c_err + c_inv), 0);
    check("glitch_digit", 32'(bus.digit), 1);

    // Latency: outputs update at the 2nd edge after first sample
    bus.disp = 8'h5B;
    @(negedge clk);
    check("lat_e0_new", 32'(bus.new_digit), 0);
    @(negedge clk);
    check("lat_e1_new", 32'(bus.new_digit), 0);
    @(negedge clk);
    check("lat_e2_new", 32'(bus.new_digit), 1);
    check("lat_e2_ok", 32'(bus.step_ok), 1);
    check("lat_e2_digit", 32'(bus.digit), 2);
    clr();
    run(8'h5B, 5);
    check("held_once_new", 32'(c_new), 0);
    check("held_once_ok", 32'(c_ok), 0);

    // Illegal pattern drops tracking
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    clr();
    run(8'h49, 10);
    check("illegal_inv", 32'(c_inv), 1);
    check("illegal_new", 32'(c_new), 0);
    check("illegal_valid", 32'(bus.valid), 0);
    check("illegal_errcnt", 32'(bus.err_count), 1);
    clr();
    run(8'h06, 10);
    check("after_illegal_new", 32'(c_new), 1);
    check("after_illegal_step", 32'(c_ok + c_err), 0);
    clr();
    run(8'h5B, 10);
    check("after_illegal_ok", 32'(c_ok), 1);
    check("after_illegal_errcnt", 32'(bus.err_count), 1);

    // Blank resets the reference without an error
    clr();
    run(8'h3F, 10);
    check("two_to_zero_err", 32'(c_err), 1);
    check("two_to_zero_errcnt", 32'(bus.err_count), 2);
    clr();
    run(8'h00, 10);
    check("blank_valid", 32'(bus.valid), 0);
    check("blank_pulses", 32'(c_new + c_ok + c_err + c_inv), 0);
    check("blank_digit_hold", 32'(bus.digit), 0);
    clr();
    run(8'h4F, 10);
    check("after_blank_new", 32'(c_new), 1);
    check("after_blank_step", 32'(c_ok + c_err + c_inv), 0);
    check("after_blank_errcnt", 32'(bus.err_count), 2);
    check("after_blank_valid", 32'(bus.valid), 1);
    check("after_blank_digit", 32'(bus.digit), 3);

    // dp toggling is not a pattern change
    clr();
    for (int i = 0; i < 10; i++) begin
      run(8'hCF, 1);
      run(8'h4F, 1);
    end
    check("dp_new", 32'(c_new), 0);
    check("dp_pulses", 32'(c_ok + c_err + c_inv), 0);

    // Error counter saturation
    clr();
    for (int i = 0; i < 130; i++) begin
      run(8'h3F, 3);
      run(8'h5B, 3);
    end
    check("sat_err_pulses", 32'(c_err), 260);
    check("sat_errcnt", 32'(bus.err_count), 255);
    check("exclusive_pulses", 32'(c_multi), 0);

    // Reset in the middle of a stability window
    bus.disp = 8'h06;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check_reset_state("midreset");
    rst = 1'b0;
    clr();
    run(8'h06, 10);
    check("post_reset_new", 32'(c_new), 1);
    check("post_reset_step", 32'(c_ok + c_err + c_inv), 0);
    check("post_reset_digit", 32'(bus.digit), 1);
    check("post_reset_errcnt", 32'(bus.err_count), 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
